// File: rtl/hpu_reset_seq.sv
// rtl/hpu_reset_seq.sv - HPU soft reset sequencer: drain, ordered assert, hold, reverse release
module hpu_reset_seq #(
  parameter int SUBDOM_NB    = 4,
  parameter int RST_HOLD_CYC = 16,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                 cfg_clk,
  input  logic                 cfg_srst,
  input  logic                 hpu_reset,
  output logic                 hpu_reset_done,
  output logic [SUBDOM_NB-1:0] flush_req,
  input  logic [SUBDOM_NB-1:0] sub_idle,
  output logic [SUBDOM_NB-1:0] sub_rst,
  input  logic [SUBDOM_NB-1:0] sub_rst_done,
  output logic                 busy,
  output logic                 err_drain_to,
  output logic [SUBDOM_NB-1:0] err_rel_to
);

  localparam int TMAX = (TIMEOUT_CYC > RST_HOLD_CYC) ? TIMEOUT_CYC : RST_HOLD_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam int IW   = $clog2(SUBDOM_NB) + 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(RST_HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SUBDOM_NB - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    ASSERT  = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 rel_first, rel_first_n;
  logic [SUBDOM_NB-1:0] flush_n, sub_rst_n, err_rel_n;
  logic                 done_n, busy_n, err_drain_n;
  logic [SUBDOM_NB-1:0] idx_mask;
  logic                 idx_done;
  logic                 rel_exit;

  // One-hot selection avoids a variable-width bit index into the sub-domain vectors
  assign idx_mask = SUBDOM_NB'(1) << idx;
  assign idx_done = |(sub_rst_done & idx_mask);

  // State register and all registered outputs; cfg_srst returns everything to IDLE/zero
  always_ff @(posedge cfg_clk) begin
    if (cfg_srst) begin
      state          <= IDLE;
      timer          <= '0;
      idx            <= '0;
      rel_first      <= 1'b0;
      flush_req      <= '0;
      sub_rst        <= '0;
      hpu_reset_done <= 1'b0;
      busy           <= 1'b0;
      err_drain_to   <= 1'b0;
      err_rel_to     <= '0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      idx            <= idx_n;
      rel_first      <= rel_first_n;
      flush_req      <= flush_n;
      sub_rst        <= sub_rst_n;
      hpu_reset_done <= done_n;
      busy           <= busy_n;
      err_drain_to   <= err_drain_n;
      err_rel_to     <= err_rel_n;
    end
  end

  // Next-state and next-output logic; every register holds unless a state updates it
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    idx_n       = idx;
    rel_first_n = rel_first;
    flush_n     = flush_req;
    sub_rst_n   = sub_rst;
    done_n      = hpu_reset_done;
    err_drain_n = err_drain_to;
    err_rel_n   = err_rel_to;
    rel_exit    = 1'b0;

    case (state)
      IDLE: begin
        if (hpu_reset) begin
          state_n     = DRAIN;
          flush_n     = '1;
          timer_n     = '0;
          err_drain_n = 1'b0;
          err_rel_n   = '0;
        end
      end

      DRAIN: begin
        if (&sub_idle) begin
          state_n = ASSERT;
          idx_n   = '0;
        end else if (timer == TO_LAST) begin
          state_n     = ASSERT;
          idx_n       = '0;
          err_drain_n = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      ASSERT: begin
        sub_rst_n = sub_rst | idx_mask;
        if (idx == IDX_LAST) begin
          state_n = HOLD;
          timer_n = '0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      HOLD: begin
        if (timer == HOLD_LAST) begin
          state_n     = RELEASE;
          idx_n       = IDX_LAST;
          flush_n     = '0;
          timer_n     = '0;
          rel_first_n = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      RELEASE: begin
        if (rel_first) begin
          // Drop this sub-domain's reset; its done flag is only trusted from next cycle
          sub_rst_n   = sub_rst & ~idx_mask;
          rel_first_n = 1'b0;
          timer_n     = timer + TW'(1);
        end else begin
          if (idx_done) begin
            rel_exit = 1'b1;
          end else if (timer == TO_LAST) begin
            rel_exit  = 1'b1;
            err_rel_n = err_rel_to | idx_mask;
          end else begin
            timer_n = timer + TW'(1);
          end
          if (rel_exit) begin
            if (idx == '0) begin
              state_n = DONE;
            end else begin
              idx_n       = idx - IW'(1);
              timer_n     = '0;
              rel_first_n = 1'b1;
            end
          end
        end
      end

      DONE: begin
        // First DONE cycle raises the ack; it then waits for the request to fall
        if (!hpu_reset_done) begin
          done_n = 1'b1;
        end else if (!hpu_reset) begin
          done_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE) && (state_n != DONE);
  end

endmodule

// File: tb/tb_hpu_reset_seq.sv
// tb/tb_hpu_reset_seq.sv - directed self-checking bench for hpu_reset_seq
module tb_hpu_reset_seq;

  logic       cfg_clk;
  logic       cfg_srst;
  logic       hpu_reset;
  logic       hpu_reset_done;
  logic [3:0] flush_req;
  logic [3:0] sub_idle;
  logic [3:0] sub_rst;
  logic [3:0] sub_rst_done;
  logic       busy;
  logic       err_drain_to;
  logic [3:0] err_rel_to;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic       imm_mode;
  logic [3:0] stuck_mask;
  logic [3:0] d1, d2, prev;
  int         rise_cyc [4];
  int         fall_cyc [4];

  hpu_reset_seq #(
    .SUBDOM_NB   (4),
    .RST_HOLD_CYC(16),
    .TIMEOUT_CYC (64)
  ) dut (
    .cfg_clk       (cfg_clk),
    .cfg_srst      (cfg_srst),
    .hpu_reset     (hpu_reset),
    .hpu_reset_done(hpu_reset_done),
    .flush_req     (flush_req),
    .sub_idle      (sub_idle),
    .sub_rst       (sub_rst),
    .sub_rst_done  (sub_rst_done),
    .busy          (busy),
    .err_drain_to  (err_drain_to),
    .err_rel_to    (err_rel_to)
  );

  initial begin
    cfg_clk = 1'b0;
    forever #5 cfg_clk = ~cfg_clk;
  end

  // Cycle counter and a sub-domain model that reports ready two cycles after release
  always @(posedge cfg_clk) begin
    cyc <= cyc + 1;
    d1  <= ~sub_rst;
    d2  <= d1;
  end

  assign sub_rst_done = (imm_mode ? ~sub_rst : d2) & ~stuck_mask;

  // Record the cycle at which each reset bit rises and falls
  always @(negedge cfg_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!prev[i] && sub_rst[i]) rise_cyc[i] <= cyc;
      if (prev[i] && !sub_rst[i]) fall_cyc[i] <= cyc;
    end
    prev <= sub_rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge cfg_clk);
  endtask

  task automatic wait_done(input int st, output int lat);
    int k;
    k = 0;
    while (hpu_reset_done !== 1'b1 && k < 400) begin
      @(negedge cfg_clk);
      k++;
    end
    lat = (hpu_reset_done === 1'b1) ? (cyc - st) : -1;
  endtask

  int st;
  int lat;

  initial begin
    cfg_srst   = 1'b1;
    hpu_reset  = 1'b0;
    sub_idle   = 4'hF;
    imm_mode   = 1'b0;
    stuck_mask = 4'h0;
    tick(3);
    check("rst_done",  hpu_reset_done, 0);
    check("rst_flush", flush_req, 0);
    check("rst_subrst", sub_rst, 0);
    check("rst_busy",  busy, 0);
    check("rst_errd",  err_drain_to, 0);
    check("rst_errr",  err_rel_to, 0);
    cfg_srst = 1'b0;
    tick(2);

    // Scenario 1: nominal with delayed ready
    hpu_reset = 1'b1; st = cyc;
    tick(1);
    check("s1_busy",  busy, 1);
    check("s1_flush", flush_req, 4'hF);
    tick(5);
    for (int i = 0; i < 16; i++) begin
      check("s1_hold", sub_rst, 4'hF);
      tick(1);
    end
    wait_done(st, lat);
    check("s1_lat", lat, 39);
    for (int i = 0; i < 4; i++) check("s1_rise", rise_cyc[i] - st, 3 + i);
    check("s1_fall3", fall_cyc[3] - st, 23);
    check("s1_fall2", fall_cyc[2] - fall_cyc[3], 4);
    check("s1_fall1", fall_cyc[1] - fall_cyc[2], 4);
    check("s1_fall0", fall_cyc[0] - fall_cyc[1], 4);
    tick(3);
    check("s1_done_hold", hpu_reset_done, 1);
    check("s1_busy_done", busy, 0);
    check("s1_errd", err_drain_to, 0);
    check("s1_errr", err_rel_to, 0);
    hpu_reset = 1'b0;
    tick(1);
    check("s1_done_fall", hpu_reset_done, 0);
    check("s1_flush_end", flush_req, 0);
    tick(2);

    // Scenario 2: drain timeout
    imm_mode = 1'b1; sub_idle = 4'b0111;
    hpu_reset = 1'b1; st = cyc;
    wait_done(st, lat);
    check("s2_lat",   lat, 94);
    check("s2_rise0", rise_cyc[0] - st, 66);
    check("s2_errd",  err_drain_to, 1);
    check("s2_errr",  err_rel_to, 0);
    hpu_reset = 1'b0; sub_idle = 4'hF;
    tick(1);
    check("s2_done_fall", hpu_reset_done, 0);
    tick(2);

    // Scenario 3: release timeout on sub-domain 2
    stuck_mask = 4'b0100;
    hpu_reset = 1'b1; st = cyc;
    wait_done(st, lat);
    check("s3_lat",   lat, 93);
    check("s3_fall2", fall_cyc[2] - fall_cyc[3], 2);
    check("s3_fall1", fall_cyc[1] - fall_cyc[2], 64);
    check("s3_fall0", fall_cyc[0] - fall_cyc[1], 2);
    check("s3_errr",  err_rel_to, 4'b0100);
    check("s3_errd",  err_drain_to, 0);
    hpu_reset = 1'b0; stuck_mask = 4'h0;
    tick(3);

    // Scenario 4: request dropped during HOLD
    hpu_reset = 1'b1; st = cyc;
    tick(10);
    check("s4_busy_hold", busy, 1);
    hpu_reset = 1'b0;
    wait_done(st, lat);
    check("s4_lat", lat, 31);
    tick(1);
    check("s4_pulse", hpu_reset_done, 0);
    check("s4_idle",  busy, 0);
    check("s4_errr",  err_rel_to, 0);
    tick(2);

    // Scenario 5: cfg_srst during HOLD clears everything
    sub_idle = 4'b0111;
    hpu_reset = 1'b1; st = cyc;
    tick(75);
    check("s5_pre_errd",  err_drain_to, 1);
    check("s5_pre_subrst", sub_rst, 4'hF);
    cfg_srst = 1'b1; hpu_reset = 1'b0;
    tick(1);
    check("s5_subrst", sub_rst, 0);
    check("s5_flush",  flush_req, 0);
    check("s5_busy",   busy, 0);
    check("s5_errd",   err_drain_to, 0);
    check("s5_done",   hpu_reset_done, 0);
    cfg_srst = 1'b0; sub_idle = 4'hF;
    tick(1);
    hpu_reset = 1'b1; st = cyc;
    wait_done(st, lat);
    check("s5_lat", lat, 31);
    check("s5_errr", err_rel_to, 0);
    hpu_reset = 1'b0;
    tick(3);

    // Scenario 6: back-to-back, first sequence leaves an error flag set
    sub_idle = 4'b0111;
    hpu_reset = 1'b1; st = cyc;
    wait_done(st, lat);
    check("s6a_lat",  lat, 94);
    check("s6a_errd", err_drain_to, 1);
    hpu_reset = 1'b0;
    tick(1);
    check("s6_done_fall", hpu_reset_done, 0);
    hpu_reset = 1'b1; sub_idle = 4'hF; imm_mode = 1'b0; st = cyc;
    tick(1);
    check("s6_busy",  busy, 1);
    check("s6_flush", flush_req, 4'hF);
    check("s6_errd",  err_drain_to, 0);
    wait_done(st, lat);
    check("s6_lat", lat, 39);
    for (int i = 0; i < 4; i++) check("s6_rise", rise_cyc[i] - st, 3 + i);
    check("s6_fall3", fall_cyc[3] - st, 23);
    check("s6_fall0", fall_cyc[0] - fall_cyc[3], 12);
    hpu_reset = 1'b0;
    tick(1);
    check("s6_done_end", hpu_reset_done, 0);
    check("s6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
